// File: rtl/tictactoe_btn_cond.sv
// Push-button conditioner for the tic-tac-toe game: synchronizes, debounces and
// edge-detects five buttons, then serializes presses into one-cycle pulses (U > D > L > R > C).
module tictactoe_btn_cond #(
    parameter int DB_CYCLES = 500000,
    parameter int CNT_W     = 20
) (
    input  logic Clk,
    input  logic reset,
    input  logic BtnU_in,
    input  logic BtnD_in,
    input  logic BtnL_in,
    input  logic BtnR_in,
    input  logic BtnC_in,
    output logic BtnU,
    output logic BtnD,
    output logic BtnL,
    output logic BtnR,
    output logic BtnC
);

    localparam int N = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // Bit order everywhere: [4]=U [3]=D [2]=L [1]=R [0]=C, so a higher index wins arbitration.
    logic [N-1:0]     w_raw;
    logic [N-1:0]     w_rise;
    logic [N-1:0]     w_grant;
    logic [N-1:0]     r_sync1;
    logic [N-1:0]     r_sync2;
    logic [N-1:0]     r_db;
    logic [N-1:0]     r_db_prev;
    logic [N-1:0]     r_pending;
    logic [N-1:0]     r_pulse;
    logic [CNT_W-1:0] r_cnt [N];

    assign w_raw  = {BtnU_in, BtnD_in, BtnL_in, BtnR_in, BtnC_in};
    assign w_rise = r_db & ~r_db_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            for (int i = 0; i < N; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            for (int i = 0; i < N; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // NOTE: a default is assigned first so no path through always_comb can infer a latch.
    always_comb begin
        w_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (r_pending[i]) begin
                w_grant    = '0;
                w_grant[i] = 1'b1;
            end
        end
    end

    // A new rise ORed in after the grant clear lets a coinciding set win.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_pulse   <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | w_rise;
            r_pulse   <= w_grant;
        end
    end

    assign BtnU = r_pulse[4];
    assign BtnD = r_pulse[3];
    assign BtnL = r_pulse[2];
    assign BtnR = r_pulse[1];
    assign BtnC = r_pulse[0];

endmodule

// File: tb/tb_tictactoe_btn_cond.sv
// Directed bench for tictactoe_btn_cond with DB_CYCLES=4: latency, glitch rejection,
// priority serialization, re-press and reset behaviour, all observed on the pulse outputs.
module tb_tictactoe_btn_cond;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    logic BtnU_in = 1'b0, BtnD_in = 1'b0, BtnL_in = 1'b0, BtnR_in = 1'b0, BtnC_in = 1'b0;
    logic BtnU, BtnD, BtnL, BtnR, BtnC;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int multi_hot = 0;
    int pulse_cyc[$];
    logic [4:0] pulse_btn[$];
    int base;

    localparam logic [4:0] B_U = 5'b10000, B_D = 5'b01000, B_L = 5'b00100,
                           B_R = 5'b00010, B_C = 5'b00001;

    tictactoe_btn_cond #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .Clk(Clk), .reset(reset),
        .BtnU_in(BtnU_in), .BtnD_in(BtnD_in), .BtnL_in(BtnL_in),
        .BtnR_in(BtnR_in), .BtnC_in(BtnC_in),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .BtnC(BtnC)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    // Log every observed pulse with the index of the edge that launched it.
    always @(negedge Clk) begin
        logic [4:0] v;
        v = {BtnU, BtnD, BtnL, BtnR, BtnC};
        if (v != 5'b0) begin
            pulse_cyc.push_back(edge_cnt);
            pulse_btn.push_back(v);
            if ($countones(v) > 1) multi_hot++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_reset();
        {BtnU_in, BtnD_in, BtnL_in, BtnR_in, BtnC_in} = 5'b0;
        reset = 1'b1;
        wait_n(3);
        check("reset_outputs", {27'b0, BtnU, BtnD, BtnL, BtnR, BtnC}, 32'd0);
        reset = 1'b0;
        wait_n(2);
        pulse_cyc.delete();
        pulse_btn.delete();
        multi_hot = 0;
    endtask

    // Checks pulse k against an expected button and launch edge; guards against a short log.
    task automatic check_pulse(input string tag, input int k, input logic [4:0] btn, input int cyc);
        if (pulse_btn.size() > k) begin
            check({tag, "_btn"}, {27'b0, pulse_btn[k]}, {27'b0, btn});
            check({tag, "_cyc"}, pulse_cyc[k], cyc);
        end else begin
            check({tag, "_present"}, pulse_btn.size(), k + 1);
        end
    endtask

    initial begin
        // Single held press on C: pulse after edge 8 only.
        do_reset();
        base = edge_cnt;
        BtnC_in = 1'b1;
        wait_n(20);
        BtnC_in = 1'b0;
        wait_n(12);
        check("c_hold_count", pulse_btn.size(), 1);
        check_pulse("c_hold", 0, B_C, base + 8);
        check("c_hold_onehot", multi_hot, 0);

        // Glitch train on U never accepted; then a clean press has full latency.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            BtnU_in = 1'b1; wait_n(3);
            BtnU_in = 1'b0; wait_n(1);
        end
        wait_n(8);
        check("glitch_count", pulse_btn.size(), 0);
        base = edge_cnt;
        BtnU_in = 1'b1;
        wait_n(12);
        BtnU_in = 1'b0;
        wait_n(10);
        check("post_glitch_count", pulse_btn.size(), 1);
        check_pulse("post_glitch", 0, B_U, base + 8);

        // U, D, C together: serialized in priority order on consecutive cycles.
        do_reset();
        base = edge_cnt;
        {BtnU_in, BtnD_in, BtnC_in} = 3'b111;
        wait_n(15);
        {BtnU_in, BtnD_in, BtnC_in} = 3'b000;
        wait_n(10);
        check("udc_count", pulse_btn.size(), 3);
        check_pulse("udc_0", 0, B_U, base + 8);
        check_pulse("udc_1", 1, B_D, base + 9);
        check_pulse("udc_2", 2, B_C, base + 10);
        check("udc_onehot", multi_hot, 0);

        // L, R, C together, U one cycle later: U jumps the queue ahead of R and C.
        do_reset();
        base = edge_cnt;
        {BtnL_in, BtnR_in, BtnC_in} = 3'b111;
        wait_n(1);
        BtnU_in = 1'b1;
        wait_n(15);
        {BtnU_in, BtnL_in, BtnR_in, BtnC_in} = 4'b0;
        wait_n(10);
        check("late_u_count", pulse_btn.size(), 4);
        check_pulse("late_u_0", 0, B_L, base + 8);
        check_pulse("late_u_1", 1, B_U, base + 9);
        check_pulse("late_u_2", 2, B_R, base + 10);
        check_pulse("late_u_3", 3, B_C, base + 11);

        // L press / release / press: two pulses 20 cycles apart.
        do_reset();
        base = edge_cnt;
        BtnL_in = 1'b1; wait_n(10);
        BtnL_in = 1'b0; wait_n(10);
        BtnL_in = 1'b1; wait_n(10);
        BtnL_in = 1'b0; wait_n(12);
        check("l_repress_count", pulse_btn.size(), 2);
        check_pulse("l_repress_0", 0, B_L, base + 8);
        check_pulse("l_repress_1", 1, B_L, base + 28);

        // R held, reset pulsed mid-debounce: one pulse 8 edges after release.
        do_reset();
        base = edge_cnt;
        BtnR_in = 1'b1;
        repeat (6) @(posedge Clk);
        #2 reset = 1'b1;
        #2 check("mid_reset_outputs", {27'b0, BtnU, BtnD, BtnL, BtnR, BtnC}, 32'd0);
        @(posedge Clk);
        #1 reset = 1'b0;
        base = edge_cnt;
        wait_n(14);
        BtnR_in = 1'b0;
        wait_n(10);
        check("r_reset_count", pulse_btn.size(), 1);
        check_pulse("r_reset", 0, B_R, base + 8);

        // Reset while pulses are pending: everything discarded.
        do_reset();
        base = edge_cnt;
        {BtnU_in, BtnD_in, BtnC_in} = 3'b111;
        repeat (8) @(posedge Clk);
        #2 reset = 1'b1;
        {BtnU_in, BtnD_in, BtnC_in} = 3'b000;
        #2 check("pend_reset_outputs", {27'b0, BtnU, BtnD, BtnL, BtnR, BtnC}, 32'd0);
        wait_n(2);
        reset = 1'b0;
        wait_n(15);
        check("pend_reset_count", pulse_btn.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tictactoe_btn_cond.md
TICTACTOE_BTN_COND -- requirements
Module: tictactoe_btn_cond

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 500000, meaning the number of consecutive stable synchronized samples needed to accept a level change.
REQ-002 The block SHALL have parameter CNT_W, default 20, meaning the debounce counter width; it SHALL be at least ceil(log2(DB_CYCLES)).
REQ-003 The block SHALL run from one clock and use an asynchronous, active-high reset.
REQ-004 Port Clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Ports BtnU_in, BtnD_in, BtnL_in, BtnR_in, BtnC_in  input  1 each  raw asynchronous push-buttons, active-high.
REQ-007 Ports BtnU, BtnD, BtnL, BtnR, BtnC  output  1 each  registered single-cycle press pulses for the game state machine.

Function
REQ-008 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2) before any other logic sees it.
REQ-009 Each button SHALL have a debounced level db (reset 0) and a counter cnt (reset 0).
REQ-010 On each edge where sync2 equals db, cnt SHALL be cleared to 0.
REQ-011 On each edge where sync2 differs from db, cnt SHALL increment; on the DB_CYCLES-th consecutive such edge, db SHALL take the sync2 value and cnt SHALL clear.
REQ-012 Any single-cycle disagreement SHALL restart the count, so glitches shorter than DB_CYCLES cycles SHALL never change db.
REQ-013 A rising edge of db (db=1, db_prev=0, where db_prev is db delayed one cycle) SHALL set that button's pending bit; a falling edge SHALL have no effect.
REQ-014 Arbiter: each cycle with any pending bit set, the highest-priority pending button SHALL be pulsed on the next edge and its pending bit cleared; priority is U > D > L > R > C.
REQ-015 At most one of BtnU/BtnD/BtnL/BtnR/BtnC SHALL be high in any cycle.
REQ-016 Each accepted press SHALL produce exactly one pulse, exactly one cycle wide, regardless of hold duration.
REQ-017 Simultaneous presses SHALL be serialized on consecutive cycles in priority order; none SHALL be dropped.
REQ-018 If a set and a clear of the same pending bit coincide, the set SHALL win.
REQ-019 Latency, uncontended: counting the first edge that samples raw high as edge 1, db rises at edge DB_CYCLES+2, pending sets at edge DB_CYCLES+3, and the pulse is high from edge DB_CYCLES+4 to DB_CYCLES+5.
REQ-020 Release SHALL also require DB_CYCLES stable cycles before db falls; a re-press is accepted only after db has returned to 0.

Reset
REQ-021 While reset is high, all sync flops, db, db_prev, cnt, pending bits and all five outputs SHALL be 0, asynchronously.
REQ-022 Reset asserted mid-debounce or with pulses pending SHALL discard them; no pulse SHALL appear after reset for those events.
REQ-023 A button held through reset release SHALL be treated as a new press and produce one pulse after REQ-019 latency.

Verification (DB_CYCLES=4)
REQ-024 BtnC_in high at edge 1 and held 20 cycles -> BtnC high for exactly one cycle after edge 8; no other output ever high.
REQ-025 BtnU_in toggled 1 for 3 cycles, 0 for 1 cycle, repeated 5 times -> no output pulse; db stays 0.
REQ-026 BtnU_in, BtnD_in, BtnC_in raised at the same edge and held -> BtnU, BtnD, BtnC pulse on three consecutive cycles in that order, each one cycle wide.
REQ-027 BtnL_in pressed 10 cycles, released 10 cycles, pressed 10 cycles -> exactly two BtnL pulses, separated by at least 8 cycles.
REQ-028 BtnR_in held; reset pulsed asynchronously at edge 6 (mid-debounce) and released at edge 7 -> all outputs 0 during reset; exactly one BtnR pulse, 8 edges after release.
